// File: rtl/sr_seq_pkg.sv
// Shared definitions for the SR command sequencer: state encoding, SR drive codes
// and the helper that maps a target level onto its SR code.
package sr_seq_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] GUARD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_HOLD  = HOLD,
        ST_GUARD = GUARD
    } state_t;

    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_CLR  = 2'b01;
    localparam logic [1:0] SR_SET  = 2'b10;

    // Wide enough for any hold/guard length in 1..15.
    localparam int CNT_W = $clog2(16);

    function automatic logic [1:0] sr_code(input logic tgt);
        return tgt ? SR_SET : SR_CLR;
    endfunction

endpackage

// File: rtl/sr_seq_timer.sv
// Loadable down-counter shared by the HOLD and GUARD phases; done flags a zero count.
module sr_seq_timer
    import sr_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;

    // Saturates at zero so an extra decrement can never wrap the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/sr_cmd_seq.sv
// Sequences set/clear requests into timed SR codes for a downstream SR flip-flop,
// with a guard gap after each command, a one-deep pending slot and a shadow of q.
module sr_cmd_seq
    import sr_seq_pkg::*;
#(
    parameter int HOLD_CYCLES  = 2,
    parameter int GUARD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_req,
    input  logic       clr_req,
    output logic [1:0] sr,
    output logic       busy,
    output logic       conflict,
    output logic       shadow_q
);

    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);

    state_t           r_state;
    logic [1:0]       r_sr;
    logic             r_busy;
    logic             r_conflict;
    logic             r_shadow;
    logic             r_pend_vld;
    logic             r_pend_tgt;

    state_t           w_state_next;
    logic [1:0]       w_sr_next;
    logic             w_shadow_next;
    logic             w_pend_vld_next;
    logic             w_pend_tgt_next;
    logic             w_launch;
    logic             w_launch_tgt;
    logic             w_tmr_load;
    logic [CNT_W-1:0] w_tmr_load_val;
    logic             w_tmr_dec;
    logic             w_tmr_done;
    logic             w_single;
    logic             w_both;

    assign w_single = set_req ^ clr_req;
    assign w_both   = set_req & clr_req;

    sr_seq_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_load_val),
        .i_dec      (w_tmr_dec),
        .o_done     (w_tmr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sr       <= SR_HOLD;
            r_busy     <= 1'b0;
            r_conflict <= 1'b0;
            r_shadow   <= 1'b0;
            r_pend_vld <= 1'b0;
            r_pend_tgt <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_sr       <= w_sr_next;
            r_busy     <= (w_state_next != ST_IDLE);
            r_conflict <= w_both;
            r_shadow   <= w_shadow_next;
            r_pend_vld <= w_pend_vld_next;
            r_pend_tgt <= w_pend_tgt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_sr_next       = r_sr;
        w_shadow_next   = r_shadow;
        w_pend_vld_next = r_pend_vld;
        w_pend_tgt_next = r_pend_tgt;
        w_launch        = 1'b0;
        w_launch_tgt    = 1'b0;
        w_tmr_load      = 1'b0;
        w_tmr_load_val  = '0;
        w_tmr_dec       = 1'b0;

        // While busy, a lone request overwrites the slot and a collision empties it.
        if (w_both) begin
            w_pend_vld_next = 1'b0;
        end else if (w_single) begin
            w_pend_vld_next = 1'b1;
            w_pend_tgt_next = set_req;
        end

        case (r_state)
            ST_IDLE: begin
                w_pend_vld_next = 1'b0;
                w_sr_next       = SR_HOLD;
                if (w_single && (set_req != r_shadow)) begin
                    w_launch     = 1'b1;
                    w_launch_tgt = set_req;
                end
            end
            ST_HOLD: begin
                if (w_tmr_done) begin
                    w_state_next   = ST_GUARD;
                    w_sr_next      = SR_HOLD;
                    w_shadow_next  = r_sr[1];
                    w_tmr_load     = 1'b1;
                    w_tmr_load_val = GUARD_LOAD;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            ST_GUARD: begin
                if (w_tmr_done) begin
                    // A request on this very edge takes precedence over the stored one.
                    w_pend_vld_next = 1'b0;
                    w_state_next    = ST_IDLE;
                    if (w_single) begin
                        w_launch     = (set_req != r_shadow);
                        w_launch_tgt = set_req;
                    end else if (!w_both && r_pend_vld) begin
                        w_launch     = (r_pend_tgt != r_shadow);
                        w_launch_tgt = r_pend_tgt;
                    end
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            default: begin
                w_state_next    = ST_IDLE;
                w_sr_next       = SR_HOLD;
                w_pend_vld_next = 1'b0;
            end
        endcase

        if (w_launch) begin
            w_state_next    = ST_HOLD;
            w_sr_next       = sr_code(w_launch_tgt);
            w_pend_vld_next = 1'b0;
            w_tmr_load      = 1'b1;
            w_tmr_load_val  = HOLD_LOAD;
        end
    end

    assign sr       = r_sr;
    assign busy     = r_busy;
    assign conflict = r_conflict;
    assign shadow_q = r_shadow;

endmodule

// File: tb/tb_sr_cmd_seq.sv
// Self-checking bench for sr_cmd_seq: directed vector table, async reset corner,
// then random requests against a queue-based schedule model.
module tb_sr_cmd_seq;

    localparam int H = 2;
    localparam int G = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       set_req = 1'b0;
    logic       clr_req = 1'b0;
    logic [1:0] sr;
    logic       busy;
    logic       conflict;
    logic       shadow_q;

    int total = 0;
    int bad   = 0;

    sr_cmd_seq #(.HOLD_CYCLES(H), .GUARD_CYCLES(G)) dut (
        .clk      (clk),
        .rst      (rst),
        .set_req  (set_req),
        .clr_req  (clr_req),
        .sr       (sr),
        .busy     (busy),
        .conflict (conflict),
        .shadow_q (shadow_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       s;
        logic       c;
        logic [1:0] sr;
        logic       busy;
        logic       conf;
        logic       sh;
    } vec_t;

    vec_t vecs[$];

    // Reference model: each launched command becomes a list of per-cycle outputs.
    typedef struct {
        logic [1:0] code;
        logic       sh;
    } slot_t;

    slot_t m_q[$];
    logic       m_shadow;
    logic       m_pend_vld;
    logic       m_pend_tgt;
    logic [1:0] m_sr;
    logic       m_busy;
    logic       m_conf;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic c, input logic [1:0] e_sr,
                       input logic e_busy, input logic e_conf, input logic e_sh);
        vec_t v;
        v.s = s; v.c = c; v.sr = e_sr; v.busy = e_busy; v.conf = e_conf; v.sh = e_sh;
        vecs.push_back(v);
    endtask

    task automatic step(input logic s, input logic c);
        set_req = s;
        clr_req = c;
        @(posedge clk);
        #1;
        chk("sr_not_11", int'(sr == 2'b11), 0);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_shadow = 1'b0; m_pend_vld = 1'b0; m_pend_tgt = 1'b0;
        m_sr = 2'b00; m_busy = 1'b0; m_conf = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic c);
        logic cand_v;
        logic cand_t;
        slot_t e;
        m_conf = s & c;
        if (m_q.size() == 0) begin
            cand_v = 1'b0;
            cand_t = 1'b0;
            if (s != c) begin
                cand_v = 1'b1; cand_t = s;
            end else if (!(s && c) && m_pend_vld) begin
                cand_v = 1'b1; cand_t = m_pend_tgt;
            end
            m_pend_vld = 1'b0;
            if (cand_v && (cand_t != m_shadow)) begin
                for (int k = 0; k < H; k++) begin
                    e.code = cand_t ? 2'b10 : 2'b01; e.sh = m_shadow; m_q.push_back(e);
                end
                for (int k = 0; k < G; k++) begin
                    e.code = 2'b00; e.sh = cand_t; m_q.push_back(e);
                end
            end
        end else begin
            if (s && c) m_pend_vld = 1'b0;
            else if (s != c) begin m_pend_vld = 1'b1; m_pend_tgt = s; end
        end
        if (m_q.size() != 0) begin
            e = m_q.pop_front();
            m_sr = e.code; m_shadow = e.sh; m_busy = 1'b1;
        end else begin
            m_sr = 2'b00; m_busy = 1'b0;
        end
    endtask

    initial begin
        // set / sr / busy sequence from reset, then drop, conflict, clear
        add(1,0,2'b10,1,0,0); add(0,0,2'b10,1,0,0); add(0,0,2'b00,1,0,1); add(0,0,2'b00,0,0,1);
        add(1,0,2'b00,0,0,1); add(0,0,2'b00,0,0,1);
        add(1,1,2'b00,0,1,1); add(0,0,2'b00,0,0,1);
        add(0,1,2'b01,1,0,1); add(0,0,2'b01,1,0,1); add(0,0,2'b00,1,0,0); add(0,0,2'b00,0,0,0);
        // clr during HOLD of a set launches at GUARD exit
        add(1,0,2'b10,1,0,0); add(0,1,2'b10,1,0,0); add(0,0,2'b00,1,0,1);
        add(0,0,2'b01,1,0,1); add(0,0,2'b01,1,0,1); add(0,0,2'b00,1,0,0); add(0,0,2'b00,0,0,0);
        // request on the final GUARD edge
        add(1,0,2'b10,1,0,0); add(0,0,2'b10,1,0,0); add(0,0,2'b00,1,0,1);
        add(0,1,2'b01,1,0,1); add(0,0,2'b01,1,0,1); add(0,0,2'b00,1,0,0); add(0,0,2'b00,0,0,0);
        // conflict during HOLD completes the command
        add(1,0,2'b10,1,0,0); add(1,1,2'b10,1,1,0); add(0,0,2'b00,1,0,1); add(0,0,2'b00,0,0,1);
        // redundant pending is dropped
        add(0,1,2'b01,1,0,1); add(0,1,2'b01,1,0,1); add(0,0,2'b00,1,0,0); add(0,0,2'b00,0,0,0);
        // newer pending overwrites older
        add(1,0,2'b10,1,0,0); add(1,0,2'b10,1,0,0); add(0,1,2'b00,1,0,1);
        add(0,0,2'b01,1,0,1); add(0,0,2'b01,1,0,1); add(0,0,2'b00,1,0,0); add(0,0,2'b00,0,0,0);
        // conflict clears pending
        add(1,0,2'b10,1,0,0); add(0,1,2'b10,1,0,0); add(1,1,2'b00,1,1,1); add(0,0,2'b00,0,0,1);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", int'({sr, busy, conflict, shadow_q}), 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].s, vecs[i].c);
            chk($sformatf("vec%0d", i), int'({sr, busy, conflict, shadow_q}),
                int'({vecs[i].sr, vecs[i].busy, vecs[i].conf, vecs[i].sh}));
            $display("vec %0d: set=%0b clr=%0b sr=%02b busy=%0b conf=%0b q=%0b",
                     i, vecs[i].s, vecs[i].c, sr, busy, conflict, shadow_q);
        end

        // async reset in the first HOLD cycle of a set (shadow is 1 here, use clr then set)
        step(0, 1);
        chk("pre_rst_hold", int'({sr, busy}), int'({2'b01, 1'b1}));
        step(0, 0);
        step(0, 0);
        step(0, 0);
        step(1, 0);
        chk("set_hold_before_rst", int'({sr, busy, shadow_q}), int'({2'b10, 1'b1, 1'b0}));
        #2 rst = 1'b1;
        #1;
        chk("async_rst", int'({sr, busy, conflict, shadow_q}), 0);
        rst = 1'b0;
        step(1, 0);
        chk("first_edge_after_rst", int'({sr, busy, conflict, shadow_q}),
            int'({2'b10, 1'b1, 1'b0, 1'b0}));
        $display("async reset corner: sr=%02b busy=%0b q=%0b", sr, busy, shadow_q);

        // random phase
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            logic s;
            logic c;
            s = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 3) == 0);
            if ((i % 701) == 700) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
                model_reset();
                chk($sformatf("rand_rst%0d", i), int'({sr, busy, conflict, shadow_q}), 0);
            end
            step(s, c);
            model_step(s, c);
            chk($sformatf("rand%0d", i), int'({sr, busy, conflict, shadow_q}),
                int'({m_sr, m_busy, m_conf, m_shadow}));
            $display("rand %0d: set=%0b clr=%0b sr=%02b/%02b busy=%0b/%0b conf=%0b/%0b q=%0b/%0b",
                     i, s, c, sr, m_sr, busy, m_busy, conflict, m_conf, shadow_q, m_shadow);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
